// File: rtl/sh4_exwb.sv
// SH4 EX/WB stage: single-entry result register, 16x32 GPR file, M/Q/S/T flags,
// retire counter. Optional operand forwarding when SH4_EXWB_BYPASS_EN is defined.
module sh4_exwb (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [3:0]  ex_flags,
  input  logic        ex_wen,
  input  logic [3:0]  ex_wdst,
  input  logic [31:0] ex_wdata,
  input  logic        wb_stall,
  input  logic [3:0]  rd_addr_a,
  input  logic [3:0]  rd_addr_b,
  output logic [31:0] rd_data_a,
  output logic [31:0] rd_data_b,
  output logic [3:0]  flags,
  output logic        hazard,
  output logic        retire,
  output logic [31:0] retire_cnt
);

  logic        wb_valid;
  logic        wb_wen;
  logic [3:0]  wb_dst;
  logic [31:0] wb_data;
  logic [3:0]  wb_flags;
  logic [31:0] rf [16];
  logic [3:0]  sr_flags;
  logic        retire_q;
  logic [31:0] retire_cnt_q;

  logic accept;
  logic commit;

  assign ex_ready   = !wb_valid || !wb_stall;
  assign accept     = ex_valid && ex_ready;
  assign commit     = wb_valid && !wb_stall;
  assign retire     = retire_q;
  assign retire_cnt = retire_cnt_q;

  // pending entry register; a same-edge commit+accept keeps wb_valid set
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_wen   <= 1'b0;
      wb_dst   <= 4'd0;
      wb_data  <= 32'd0;
      wb_flags <= 4'd0;
    end else if (accept) begin
      wb_valid <= 1'b1;
      wb_wen   <= ex_wen;
      wb_dst   <= ex_wdst;
      wb_data  <= ex_wdata;
      wb_flags <= ex_flags;
    end else if (commit) begin
      wb_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) rf[i] <= 32'd0;
      sr_flags     <= 4'd0;
      retire_q     <= 1'b0;
      retire_cnt_q <= 32'd0;
    end else begin
      retire_q <= commit;
      if (commit) begin
        sr_flags     <= wb_flags;
        retire_cnt_q <= retire_cnt_q + 32'd1;
        if (wb_wen) rf[wb_dst] <= wb_data;
      end
    end
  end

`ifdef SH4_EXWB_BYPASS_EN
  always_comb begin
    rd_data_a = rf[rd_addr_a];
    rd_data_b = rf[rd_addr_b];
    if (wb_valid && wb_wen && wb_dst == rd_addr_a) rd_data_a = wb_data;
    if (wb_valid && wb_wen && wb_dst == rd_addr_b) rd_data_b = wb_data;
  end

  assign flags  = wb_valid ? wb_flags : sr_flags;
  assign hazard = 1'b0;
`else
  always_comb begin
    rd_data_a = rf[rd_addr_a];
    rd_data_b = rf[rd_addr_b];
  end

  // without forwarding, stall issue on a pending GPR write or flag change
  assign flags  = sr_flags;
  assign hazard = wb_valid &&
                  ((wb_wen && (wb_dst == rd_addr_a || wb_dst == rd_addr_b)) ||
                   wb_flags != sr_flags);
`endif

endmodule

// File: tb/tb_sh4_exwb.sv
// Self-checking bench for sh4_exwb: directed scenarios plus a randomized run
// compared against a transaction-level reference model.
module tb_sh4_exwb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [3:0]  ex_flags = 4'd0;
  logic        ex_wen = 1'b0;
  logic [3:0]  ex_wdst = 4'd0;
  logic [31:0] ex_wdata = 32'd0;
  logic        wb_stall = 1'b0;
  logic [3:0]  rd_addr_a = 4'd0;
  logic [3:0]  rd_addr_b = 4'd0;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic [3:0]  flags;
  logic        hazard;
  logic        retire;
  logic [31:0] retire_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  sh4_exwb dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_flags(ex_flags), .ex_wen(ex_wen), .ex_wdst(ex_wdst), .ex_wdata(ex_wdata),
    .wb_stall(wb_stall),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .flags(flags), .hazard(hazard), .retire(retire), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  // reference model: architectural state plus at most one pending result
  logic [31:0] m_rf [16];
  logic [3:0]  m_sr;
  logic [31:0] m_cnt;
  logic        m_retire;
  logic        p_v;
  logic        p_wen;
  logic [3:0]  p_dst;
  logic [31:0] p_data;
  logic [3:0]  p_flags;

`ifdef SH4_EXWB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  function automatic logic exp_ready();
    return !p_v || !wb_stall;
  endfunction

  function automatic logic [3:0] exp_flags();
    if (BYPASS && p_v) return p_flags;
    return m_sr;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [3:0] a);
    if (BYPASS && p_v && p_wen && p_dst == a) return p_data;
    return m_rf[a];
  endfunction

  function automatic logic exp_hazard();
    if (BYPASS) return 1'b0;
    return p_v && ((p_wen && (p_dst == rd_addr_a || p_dst == rd_addr_b)) || p_flags != m_sr);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_rf[i] = 32'd0;
    m_sr = 4'd0; m_cnt = 32'd0; m_retire = 1'b0;
    p_v = 1'b0; p_wen = 1'b0; p_dst = 4'd0; p_data = 32'd0; p_flags = 4'd0;
  endtask

  // drive one cycle of inputs, clock it, advance the model, sample point #1 after edge
  task automatic cycle(input logic v, input logic [3:0] fl, input logic w,
                       input logic [3:0] d, input logic [31:0] dat, input logic st);
    logic com, acc;
    ex_valid = v; ex_flags = fl; ex_wen = w; ex_wdst = d; ex_wdata = dat; wb_stall = st;
    @(posedge clk);
    com = p_v && !st;
    acc = v && (!p_v || !st);
    m_retire = com;
    if (com) begin
      m_sr = p_flags;
      if (p_wen) m_rf[p_dst] = p_data;
      m_cnt = m_cnt + 32'd1;
    end
    if (acc) begin
      p_v = 1'b1; p_wen = w; p_dst = d; p_data = dat; p_flags = fl;
    end else if (com) begin
      p_v = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    model_clear();
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rd_addr_a = 4'd3; rd_addr_b = 4'd12; #1;
    n_cmp++; if (ex_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ex_ready: got %b exp 1", ex_ready); end
    n_cmp++; if (flags !== 4'h0) begin n_bad++; $display("FAIL reset_flags: got %h exp 0", flags); end
    n_cmp++; if (hazard !== 1'b0) begin n_bad++; $display("FAIL reset_hazard: got %b exp 0", hazard); end
    n_cmp++; if (rd_data_a !== 32'd0 || rd_data_b !== 32'd0) begin n_bad++; $display("FAIL reset_rd: got %h/%h exp 0/0", rd_data_a, rd_data_b); end
    n_cmp++; if (retire !== 1'b0 || retire_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_retire: got %b/%h exp 0/0", retire, retire_cnt); end
  endtask

  task automatic test_basic();
    cycle(1'b1, 4'h1, 1'b1, 4'd3, 32'h12345678, 1'b0);
    cycle(1'b0, 4'h0, 1'b0, 4'd0, 32'd0, 1'b0);
    rd_addr_a = 4'd3; #1;
    n_cmp++; if (retire !== 1'b1) begin n_bad++; $display("FAIL basic_retire: got %b exp 1", retire); end
    n_cmp++; if (rd_data_a !== 32'h12345678) begin n_bad++; $display("FAIL basic_rf3: got %h exp 12345678", rd_data_a); end
    n_cmp++; if (flags !== 4'h1) begin n_bad++; $display("FAIL basic_flags: got %h exp 1", flags); end
    n_cmp++; if (retire_cnt !== 32'd1) begin n_bad++; $display("FAIL basic_cnt: got %h exp 1", retire_cnt); end
    cycle(1'b0, 4'h0, 1'b0, 4'd0, 32'd0, 1'b0);
    n_cmp++; if (retire !== 1'b0) begin n_bad++; $display("FAIL basic_retire_pulse: got %b exp 0", retire); end
  endtask

  task automatic test_back_to_back();
    rd_addr_a = 4'd5; rd_addr_b = 4'd0;
    cycle(1'b1, 4'h1, 1'b1, 4'd5, 32'hA, 1'b0);
    if (BYPASS) begin
      n_cmp++; if (rd_data_a !== 32'hA) begin n_bad++; $display("FAIL b2b_bypass_a: got %h exp a", rd_data_a); end
    end else begin
      n_cmp++; if (hazard !== 1'b1) begin n_bad++; $display("FAIL b2b_hazard_1: got %b exp 1", hazard); end
    end
    cycle(1'b1, 4'h1, 1'b1, 4'd5, 32'hB, 1'b0);
    if (BYPASS) begin
      n_cmp++; if (rd_data_a !== 32'hB) begin n_bad++; $display("FAIL b2b_bypass_b: got %h exp b", rd_data_a); end
    end else begin
      n_cmp++; if (hazard !== 1'b1) begin n_bad++; $display("FAIL b2b_hazard_2: got %b exp 1", hazard); end
    end
    n_cmp++; if (retire !== 1'b1) begin n_bad++; $display("FAIL b2b_retire: got %b exp 1", retire); end
    cycle(1'b0, 4'h0, 1'b0, 4'd0, 32'd0, 1'b0);
    n_cmp++; if (rd_data_a !== 32'hB) begin n_bad++; $display("FAIL b2b_rf5: got %h exp b", rd_data_a); end
    n_cmp++; if (hazard !== 1'b0) begin n_bad++; $display("FAIL b2b_hazard_idle: got %b exp 0", hazard); end
    n_cmp++; if (retire_cnt !== m_cnt) begin n_bad++; $display("FAIL b2b_cnt: got %h exp %h", retire_cnt, m_cnt); end
  endtask

  task automatic test_stall();
    logic [31:0] cnt0;
    cycle(1'b1, 4'h2, 1'b1, 4'd9, 32'h99, 1'b0);
    cnt0 = m_cnt;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 4'h3, 1'b1, 4'd10, 32'h1010, 1'b1);
      n_cmp++; if (ex_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready[%0d]: got %b exp 0", i, ex_ready); end
      n_cmp++; if (retire !== 1'b0) begin n_bad++; $display("FAIL stall_retire[%0d]: got %b exp 0", i, retire); end
      n_cmp++; if (retire_cnt !== cnt0) begin n_bad++; $display("FAIL stall_cnt[%0d]: got %h exp %h", i, retire_cnt, cnt0); end
    end
    cycle(1'b1, 4'h3, 1'b1, 4'd10, 32'h1010, 1'b0);
    n_cmp++; if (retire !== 1'b1 || retire_cnt !== cnt0 + 32'd1) begin n_bad++; $display("FAIL stall_release: got %b/%h exp 1/%h", retire, retire_cnt, cnt0 + 32'd1); end
    cycle(1'b0, 4'h0, 1'b0, 4'd0, 32'd0, 1'b0);
    rd_addr_a = 4'd9; rd_addr_b = 4'd10; #1;
    n_cmp++; if (rd_data_a !== 32'h99 || rd_data_b !== 32'h1010) begin n_bad++; $display("FAIL stall_rf: got %h/%h exp 99/1010", rd_data_a, rd_data_b); end
    n_cmp++; if (retire_cnt !== cnt0 + 32'd2) begin n_bad++; $display("FAIL stall_cnt_final: got %h exp %h", retire_cnt, cnt0 + 32'd2); end
  endtask

  task automatic test_div0();
    logic [31:0] cnt0;
    cnt0 = m_cnt;
    cycle(1'b1, 4'hC, 1'b0, 4'd3, 32'hDEAD_BEEF, 1'b0);
    cycle(1'b0, 4'h0, 1'b0, 4'd0, 32'd0, 1'b0);
    n_cmp++; if (flags !== 4'hC) begin n_bad++; $display("FAIL div0_flags: got %h exp c", flags); end
    n_cmp++; if (retire_cnt !== cnt0 + 32'd1) begin n_bad++; $display("FAIL div0_cnt: got %h exp %h", retire_cnt, cnt0 + 32'd1); end
    for (int a = 0; a < 16; a++) begin
      rd_addr_a = 4'(a); #1;
      n_cmp++; if (rd_data_a !== m_rf[a]) begin n_bad++; $display("FAIL div0_rf[%0d]: got %h exp %h", a, rd_data_a, m_rf[a]); end
    end
  endtask

  task automatic test_reset_pending();
    cycle(1'b1, 4'h0, 1'b1, 4'd7, 32'hFFFF, 1'b1);
    cycle(1'b0, 4'h0, 1'b0, 4'd0, 32'd0, 1'b1);
    n_cmp++; if (ex_ready !== 1'b0) begin n_bad++; $display("FAIL rstp_pending_ready: got %b exp 0", ex_ready); end
    do_reset();
    rd_addr_a = 4'd7; #1;
    n_cmp++; if (rd_data_a !== 32'd0) begin n_bad++; $display("FAIL rstp_rf7: got %h exp 0", rd_data_a); end
    n_cmp++; if (ex_ready !== 1'b1) begin n_bad++; $display("FAIL rstp_ready: got %b exp 1", ex_ready); end
    n_cmp++; if (retire_cnt !== 32'd0) begin n_bad++; $display("FAIL rstp_cnt: got %h exp 0", retire_cnt); end
    cycle(1'b0, 4'h0, 1'b0, 4'd0, 32'd0, 1'b0);
    n_cmp++; if (retire !== 1'b0 || rd_data_a !== 32'd0) begin n_bad++; $display("FAIL rstp_discard: got %b/%h exp 0/0", retire, rd_data_a); end
  endtask

  task automatic test_wrap();
    cycle(1'b0, 4'h0, 1'b0, 4'd0, 32'd0, 1'b0);
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    #1;
    n_cmp++; if (retire_cnt !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL wrap_preload: got %h exp ffffffff", retire_cnt); end
    cycle(1'b1, 4'h5, 1'b1, 4'd2, 32'h2222, 1'b0);
    cycle(1'b0, 4'h0, 1'b0, 4'd0, 32'd0, 1'b0);
    n_cmp++; if (retire_cnt !== 32'd0) begin n_bad++; $display("FAIL wrap_cnt: got %h exp 0", retire_cnt); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rd_addr_a = 4'($urandom_range(0, 15));
      rd_addr_b = 4'($urandom_range(0, 15));
      cycle(1'($urandom_range(0, 9) < 7), 4'($urandom), 1'($urandom_range(0, 3) != 0),
            4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 9) < 3));
      n_cmp++;
      if (ex_ready !== exp_ready() || hazard !== exp_hazard() || flags !== exp_flags() ||
          rd_data_a !== exp_rd(rd_addr_a) || rd_data_b !== exp_rd(rd_addr_b) ||
          retire !== m_retire || retire_cnt !== m_cnt) begin
        n_bad++;
        $display("FAIL rand[%0d]: got rdy=%b hz=%b fl=%h a=%h b=%h ret=%b cnt=%h exp rdy=%b hz=%b fl=%h a=%h b=%h ret=%b cnt=%h",
                 i, ex_ready, hazard, flags, rd_data_a, rd_data_b, retire, retire_cnt,
                 exp_ready(), exp_hazard(), exp_flags(), exp_rd(rd_addr_a), exp_rd(rd_addr_b), m_retire, m_cnt);
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_div0();
    test_reset_pending();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
